reg_dump_reader: RTL and testbench
==================================

Name: reg_dump_reader

Overview:
Debug-side reader for the MIPS register file. On a start pulse it walks register addresses 0..2**NB_ADDR-1 through the register file's asynchronous read port. It snapshots each word and streams it byte by byte to the UART transmitter using a start/done handshake. It sits between the register file's debug read port and the debug unit's UART TX, and it is the consumer of the contents written by the writeback stage.

Parameters:
NB_DATA, 32, register width in bits; must be a multiple of NB_BYTE
NB_ADDR, 5, register address width; the dump covers 2**NB_ADDR registers
NB_BYTE, 8, UART byte width

Ports:
clk  input  1  system clock, rising edge
i_reset  input  1  asynchronous active-low reset
i_start  input  1  one-cycle request to start a dump; ignored while o_busy=1
o_rd_addr  output  NB_ADDR  address driven to the register file debug read port
i_rd_data  input  NB_DATA  combinational read data for o_rd_addr
o_tx_data  output  NB_BYTE  byte presented to the UART TX
o_tx_start  output  1  one-cycle pulse asking the UART TX to send o_tx_data
i_tx_done  input  1  one-cycle pulse from the UART TX when the byte has been sent
o_busy  output  1  high from LOAD through DONE
o_done  output  1  one-cycle pulse when the final byte has completed

Behaviour:
- Reset (i_reset=0, async): state=IDLE; addr, byte_cnt and data snapshot = 0; all outputs = 0. A reset during a dump aborts it with no o_done pulse.
- FSM states: IDLE, LOAD, SEND, WAIT, DONE. All outputs are registered or Moore-decoded from state.
- IDLE: o_busy=0. When i_start=1: addr<=0, go to LOAD. i_tx_done is ignored.
- LOAD: data_q<=i_rd_data for the current o_rd_addr, byte_cnt<=0, then SEND. The snapshot makes register-file writes after LOAD invisible for that word.
- SEND: o_tx_start=1 for exactly this one cycle, then WAIT.
- WAIT: waits any number of cycles for i_tx_done.
  - On i_tx_done with byte_cnt < NB_DATA/NB_BYTE-1: byte_cnt+1, go to SEND.
  - On i_tx_done with the word complete and addr < 2**NB_ADDR-1: addr+1, go to LOAD.
  - On i_tx_done with the word complete and addr = max: go to DONE.
- DONE: o_done=1 for one cycle, then IDLE. addr is not wrapped or cleared until the next start.
- Byte order: MSB first. o_tx_data = data_q[NB_DATA-1-byte_cnt*NB_BYTE -: NB_BYTE]. It is stable from SEND through the end of WAIT.
- An i_tx_done arriving in SEND (same cycle as o_tx_start) is ignored; only WAIT consumes it.
- An i_start while busy is ignored and does not restart the dump.
- Timing: i_start sampled at edge n puts LOAD in cycle n+1. The first o_tx_start is high in cycle n+2.
- Per word: 1 LOAD cycle plus 4×(1 SEND cycle + WAIT time).
- Full dump with defaults: 32 words, 128 bytes, 32 LOAD cycles.
- o_rd_addr = addr at all times, and equals 0 in IDLE after reset.

Test Plan:
1. Reset mid-IDLE and mid-WAIT -> o_tx_start=o_busy=o_done=0 and o_rd_addr=0 immediately, asynchronously to clk.
2. Register model holds reg[k]=32'h11223300+k; i_start; TX model returns i_tx_done 3 cycles after each o_tx_start -> 128 bytes 11,22,33,00,11,22,33,01,...,11,22,33,1F. o_done pulses once, one cycle after the 128th i_tx_done; o_busy then drops.
3. During the dump, pulse i_start at bytes 5 and 100 -> stream identical to scenario 2; exactly 128 o_tx_start pulses and one o_done.
4. Write reg[5]=32'hDEADBEEF one cycle after LOAD of address 5 -> bytes for reg 5 are 11,22,33,05. With the write issued before LOAD of address 5 -> DE,AD,BE,EF.
5. Spurious i_tx_done in IDLE, and in SEND coincident with o_tx_start -> no state advance. The next byte is sent only after a genuine i_tx_done in WAIT.
6. Assert reset after 10 bytes, release, then i_start -> no o_done from the aborted dump; the new dump restarts at reg 0, first byte 11, full 128 bytes.

Source files
------------

// File: rtl/reg_dump_reader_if.sv
// reg_dump_reader_if: groups the signals of the register-dump reader.
//   i_start     : one-cycle dump request
//   o_rd_addr   : address to the register file debug read port
//   i_rd_data   : combinational read data for o_rd_addr
//   o_tx_data   : byte presented to the UART transmitter
//   o_tx_start  : one-cycle pulse asking the UART to send o_tx_data
//   i_tx_done   : one-cycle pulse when the UART has sent the byte
//   o_busy      : high while a dump is in progress
//   o_done      : one-cycle pulse after the final byte completes
// Modports: master = the reader itself, slave = register file / UART side.
interface reg_dump_reader_if #(
  parameter int NB_DATA = 32,
  parameter int NB_ADDR = 5,
  parameter int NB_BYTE = 8
);
  logic               i_start;
  logic [NB_ADDR-1:0] o_rd_addr;
  logic [NB_DATA-1:0] i_rd_data;
  logic [NB_BYTE-1:0] o_tx_data;
  logic               o_tx_start;
  logic               i_tx_done;
  logic               o_busy;
  logic               o_done;

  modport master (
    input  i_start, i_rd_data, i_tx_done,
    output o_rd_addr, o_tx_data, o_tx_start, o_busy, o_done
  );

  modport slave (
    output i_start, i_rd_data, i_tx_done,
    input  o_rd_addr, o_tx_data, o_tx_start, o_busy, o_done
  );
endinterface

// File: rtl/reg_dump_reader.sv
// reg_dump_reader: on a start pulse, walks every register address through
// the register file's asynchronous debug read port, snapshots each word and
// streams it MSB byte first to the UART TX with a start/done handshake.
// Ports:
//   clk     : system clock, rising edge
//   i_reset : asynchronous active-low reset
//   bus     : reg_dump_reader_if.master (start, read port, UART TX, status)
// The interface instance must use the same NB_* parameters as this module.
module reg_dump_reader #(
  parameter int NB_DATA = 32,
  parameter int NB_ADDR = 5,
  parameter int NB_BYTE = 8
) (
  input logic                clk,
  input logic                i_reset,
  reg_dump_reader_if.master  bus
);

  localparam int NB_BYTES = NB_DATA / NB_BYTE;
  localparam int NB_CNT   = (NB_BYTES > 1) ? $clog2(NB_BYTES) : 1;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_LOAD = 3'd1;
  localparam logic [2:0] ST_SEND = 3'd2;
  localparam logic [2:0] ST_WAIT = 3'd3;
  localparam logic [2:0] ST_DONE = 3'd4;

  logic [2:0]         state_q,    state_d;
  logic [NB_ADDR-1:0] addr_q,     addr_d;
  logic [NB_CNT-1:0]  byte_cnt_q, byte_cnt_d;
  logic [NB_DATA-1:0] data_q,     data_d;

  logic               byte_last;
  logic               addr_last;
  logic [NB_DATA-1:0] tx_word;

  assign byte_last = (byte_cnt_q == NB_CNT'(NB_BYTES - 1));
  assign addr_last = (addr_q == '1);

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    state_d    = state_q;
    addr_d     = addr_q;
    byte_cnt_d = byte_cnt_q;
    data_d     = data_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.i_start) begin
          addr_d  = '0;
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        // The snapshot isolates the word being sent from later register writes.
        data_d     = bus.i_rd_data;
        byte_cnt_d = '0;
        state_d    = ST_SEND;
      end
      ST_SEND: begin
        // A done pulse coinciding with tx_start belongs to no byte; ignore it.
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (bus.i_tx_done) begin
          if (!byte_last) begin
            byte_cnt_d = byte_cnt_q + 1'b1;
            state_d    = ST_SEND;
          end else if (!addr_last) begin
            addr_d  = addr_q + 1'b1;
            state_d = ST_LOAD;
          end else begin
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        // addr is left at its final value until the next start.
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q    <= ST_IDLE;
      addr_q     <= '0;
      byte_cnt_q <= '0;
      data_q     <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      byte_cnt_q <= byte_cnt_d;
      data_q     <= data_d;
    end
  end

  // MSB-first byte selection: shift the chosen byte to the top of the word.
  assign tx_word = data_q << (byte_cnt_q * NB_BYTE);

  assign bus.o_rd_addr  = addr_q;
  assign bus.o_tx_data  = tx_word[NB_DATA-1 -: NB_BYTE];
  assign bus.o_tx_start = (state_q == ST_SEND);
  assign bus.o_busy     = (state_q != ST_IDLE);
  assign bus.o_done     = (state_q == ST_DONE);

endmodule

// File: tb/tb_reg_dump_reader.sv
// tb_reg_dump_reader: drives reg_dump_reader with a register file model and a
// UART TX model answering each o_tx_start with i_tx_done three cycles later.
// Expected bytes are queued when a dump is launched and popped on every
// o_tx_start.
module tb_reg_dump_reader;

  localparam int NB_DATA = 32;
  localparam int NB_ADDR = 5;
  localparam int NB_BYTE = 8;
  localparam int NREGS   = 1 << NB_ADDR;
  localparam int NBYTES  = NREGS * (NB_DATA / NB_BYTE);

  logic clk;
  logic i_reset;

  reg_dump_reader_if #(.NB_DATA(NB_DATA), .NB_ADDR(NB_ADDR), .NB_BYTE(NB_BYTE)) bus ();

  reg_dump_reader #(.NB_DATA(NB_DATA), .NB_ADDR(NB_ADDR), .NB_BYTE(NB_BYTE)) dut (
    .clk     (clk),
    .i_reset (i_reset),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Register file model with a combinational read port.
  logic [NB_DATA-1:0] reg_mem [NREGS];
  logic [NB_DATA-1:0] exp_mem [NREGS];
  assign bus.i_rd_data = reg_mem[bus.o_rd_addr];

  // UART TX model plus a directly driven spurious-done source.
  logic tx_auto     = 1'b1;
  logic tx_done_drv = 1'b0;
  logic spur        = 1'b0;
  int   pend        = 0;
  assign bus.i_tx_done = tx_done_drv | spur;

  always begin
    @(posedge clk);
    #1;
    tx_done_drv = 1'b0;
    if (!i_reset) begin
      pend = 0;
    end else begin
      if (pend > 0) begin
        pend = pend - 1;
        if (pend == 0) tx_done_drv = 1'b1;
      end
      if (bus.o_tx_start && tx_auto) pend = 3;
    end
  end

  // Cycle counter and output monitor / scoreboard.
  int cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  logic [NB_BYTE-1:0] exp_q [$];
  int start_cnt     = 0;
  int done_cnt      = 0;
  int done_cyc      = 0;
  int last_done_cyc = 0;

  always @(negedge clk) begin
    logic [NB_BYTE-1:0] e;
    if (i_reset) begin
      if (bus.o_tx_start) begin
        start_cnt = start_cnt + 1;
        checks = checks + 1;
        if (exp_q.size() == 0) begin
          errors = errors + 1;
          $display("FAIL tx_byte: got %02h with no byte expected", bus.o_tx_data);
        end else begin
          e = exp_q.pop_front();
          if (bus.o_tx_data !== e) begin
            errors = errors + 1;
            $display("FAIL tx_byte #%0d: got %02h expected %02h",
                     start_cnt, bus.o_tx_data, e);
          end
        end
      end
      if (bus.o_done) begin
        done_cnt = done_cnt + 1;
        done_cyc = cyc;
      end
      if (tx_done_drv) last_done_cyc = cyc;
    end
  end

  int sc0, dc0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_dump();
    for (int k = 0; k < NREGS; k++)
      for (int b = 0; b < NB_DATA / NB_BYTE; b++)
        exp_q.push_back(exp_mem[k][NB_DATA-1-b*NB_BYTE -: NB_BYTE]);
  endtask

  task automatic load_default_regs();
    for (int k = 0; k < NREGS; k++) begin
      reg_mem[k] = 32'h1122_3300 + NB_DATA'(k);
      exp_mem[k] = 32'h1122_3300 + NB_DATA'(k);
    end
  endtask

  // Launch a dump from IDLE and check start -> LOAD -> first SEND timing.
  // Returns positioned at posedge+1 of the first SEND cycle.
  task automatic start_dump(input string name);
    sc0 = start_cnt;
    dc0 = done_cnt;
    tick();
    bus.i_start = 1'b1;
    tick();
    bus.i_start = 1'b0;
    checks++;
    if ({bus.o_busy, bus.o_tx_start, bus.o_rd_addr} !== {1'b1, 1'b0, 5'd0}) begin
      errors++;
      $display("FAIL %s load_cycle: busy/start/addr=%b/%b/%0d expected 1/0/0",
               name, bus.o_busy, bus.o_tx_start, bus.o_rd_addr);
    end
    tick();
    checks++;
    if (bus.o_tx_start !== 1'b1) begin
      errors++;
      $display("FAIL %s first_tx_start: got %b expected 1", name, bus.o_tx_start);
    end
  endtask

  task automatic wait_bytes(input string name, input int n);
    bit hit = 0;
    for (int i = 0; i < 5000 && !hit; i++) begin
      tick();
      if (start_cnt - sc0 >= n) hit = 1;
    end
    checks++;
    if (!hit) begin
      errors++;
      $display("FAIL %s wait_bytes: timeout at %0d bytes, expected %0d",
               name, start_cnt - sc0, n);
    end
  endtask

  task automatic wait_addr(input string name, input logic [NB_ADDR-1:0] a);
    bit hit = 0;
    for (int i = 0; i < 5000 && !hit; i++) begin
      tick();
      if (bus.o_busy && bus.o_rd_addr == a) hit = 1;
    end
    checks++;
    if (!hit) begin
      errors++;
      $display("FAIL %s wait_addr: timeout waiting for addr %0d", name, a);
    end
  endtask

  // Wait for o_done and verify the dump completed cleanly.
  task automatic finish_dump(input string name);
    bit hit = 0;
    for (int i = 0; i < 5000 && !hit; i++) begin
      @(negedge clk);
      #1;
      if (done_cnt != dc0) hit = 1;
    end
    checks++;
    if (!hit) begin
      errors++;
      $display("FAIL %s done_timeout: no o_done within budget", name);
      return;
    end
    checks++;
    if (start_cnt - sc0 !== NBYTES) begin
      errors++;
      $display("FAIL %s byte_count: got %0d expected %0d", name, start_cnt - sc0, NBYTES);
    end
    checks++;
    if (done_cyc - last_done_cyc !== 1) begin
      errors++;
      $display("FAIL %s done_latency: got %0d expected 1", name, done_cyc - last_done_cyc);
    end
    tick();
    tick();
    checks++;
    if ({bus.o_busy, bus.o_done} !== 2'b00 || done_cnt - dc0 !== 1) begin
      errors++;
      $display("FAIL %s after_done: busy=%b done=%b pulses=%0d expected 0/0/1",
               name, bus.o_busy, bus.o_done, done_cnt - dc0);
    end
    checks++;
    if (exp_q.size() !== 0) begin
      errors++;
      $display("FAIL %s leftover: %0d bytes still expected, expected 0", name, exp_q.size());
    end
    exp_q.delete();
  endtask

  task automatic check_outputs_zero(input string name);
    checks++;
    if ({bus.o_tx_start, bus.o_busy, bus.o_done, bus.o_rd_addr, bus.o_tx_data} !== '0) begin
      errors++;
      $display("FAIL %s zero_outputs: start/busy/done/addr/data=%b/%b/%b/%0d/%02h expected all 0",
               name, bus.o_tx_start, bus.o_busy, bus.o_done, bus.o_rd_addr, bus.o_tx_data);
    end
  endtask

  // Reset in IDLE and mid-WAIT (after 10 bytes); the aborted dump must not
  // signal done, and a fresh dump restarts from register 0.
  task automatic test_reset();
    int d_before;
    i_reset = 1'b0;
    #1;
    check_outputs_zero("reset_initial");
    tick();
    i_reset = 1'b1;
    tick();
    @(negedge clk);
    #2;
    i_reset = 1'b0;
    #1;
    check_outputs_zero("reset_idle");
    tick();
    i_reset = 1'b1;

    push_dump();
    start_dump("reset_abort");
    wait_bytes("reset_abort", 10);
    tick();
    checks++;
    if (bus.o_rd_addr !== 5'd2 || bus.o_busy !== 1'b1) begin
      errors++;
      $display("FAIL reset_abort pre_reset: addr=%0d busy=%b expected 2/1",
               bus.o_rd_addr, bus.o_busy);
    end
    d_before = done_cnt;
    #2;
    i_reset = 1'b0;
    #1;
    check_outputs_zero("reset_wait");
    exp_q.delete();
    repeat (3) tick();
    i_reset = 1'b1;
    repeat (5) tick();
    checks++;
    if (done_cnt !== d_before) begin
      errors++;
      $display("FAIL reset_abort no_done: got %0d pulses expected 0", done_cnt - d_before);
    end
    push_dump();
    start_dump("reset_restart");
    finish_dump("reset_restart");
  endtask

  task automatic test_full_dump();
    push_dump();
    start_dump("full_dump");
    finish_dump("full_dump");
  endtask

  task automatic test_start_while_busy();
    push_dump();
    start_dump("start_busy");
    wait_bytes("start_busy", 5);
    bus.i_start = 1'b1;
    tick();
    bus.i_start = 1'b0;
    wait_bytes("start_busy", 100);
    bus.i_start = 1'b1;
    tick();
    bus.i_start = 1'b0;
    finish_dump("start_busy");
  endtask

  task automatic test_snapshot();
    // Write one cycle after LOAD of address 5: old word is sent.
    push_dump();
    start_dump("snap_after");
    wait_addr("snap_after", 5);
    tick();
    reg_mem[5] = 32'hDEAD_BEEF;
    finish_dump("snap_after");
    reg_mem[5] = 32'h1122_3305;

    // Write before LOAD of address 5: new word is sent.
    exp_mem[5] = 32'hDEAD_BEEF;
    push_dump();
    start_dump("snap_before");
    wait_addr("snap_before", 4);
    reg_mem[5] = 32'hDEAD_BEEF;
    finish_dump("snap_before");
    reg_mem[5] = 32'h1122_3305;
    exp_mem[5] = 32'h1122_3305;
  endtask

  task automatic test_spurious_done();
    int s_before;
    tx_auto = 1'b0;
    s_before = start_cnt;
    tick();
    spur = 1'b1;
    tick();
    spur = 1'b0;
    repeat (2) tick();
    checks++;
    if (bus.o_busy !== 1'b0 || start_cnt !== s_before) begin
      errors++;
      $display("FAIL spur_idle: busy=%b new_starts=%0d expected 0/0",
               bus.o_busy, start_cnt - s_before);
    end

    push_dump();
    start_dump("spur_send");
    spur = 1'b1;
    tick();
    spur = 1'b0;
    repeat (5) tick();
    checks++;
    if (start_cnt - sc0 !== 1 || bus.o_busy !== 1'b1 || bus.o_tx_start !== 1'b0) begin
      errors++;
      $display("FAIL spur_send: starts=%0d busy=%b tx_start=%b expected 1/1/0",
               start_cnt - sc0, bus.o_busy, bus.o_tx_start);
    end
    tx_auto = 1'b1;
    spur = 1'b1;
    tick();
    spur = 1'b0;
    checks++;
    if (bus.o_tx_start !== 1'b1) begin
      errors++;
      $display("FAIL spur_genuine: tx_start=%b expected 1", bus.o_tx_start);
    end
    finish_dump("spur_send");
  endtask

  initial begin
    i_reset     = 1'b0;
    bus.i_start = 1'b0;
    load_default_regs();
    test_reset();
    test_full_dump();
    test_start_while_busy();
    test_snapshot();
    test_spurious_done();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
